// File: rtl/sr_latch_ctrl.sv
// ---------------------------------------------------------------------------
// sr_latch_ctrl
//
// Shares one external SR latch among N_REQ requesters. Set/clear requests are
// arbitrated round-robin. The winner receives a one-cycle grant. When the
// request changes the latch, the controller drives a fixed-width S or R pulse.
// A guard gap with S=R=0 follows. At the end of the gap the latch Q feedback is
// compared with the shadow of the expected latch state.
//
// After reset, an INIT pulse on R forces the latch to a known 0. The same gap
// and check follow it.
//
// Ports
//   clk       in   1      system clock, rising edge
//   rst_n     in   1      asynchronous, active-low reset
//   set_req   in   N_REQ  level request: drive latch to 1 (held until granted)
//   clr_req   in   N_REQ  level request: drive latch to 0 (held until granted)
//   latch_q   in   1      Q feedback from the SR latch
//   err_clr   in   1      synchronous clear of err
//   grant     out  N_REQ  one-hot, one-cycle acceptance pulse
//   busy      out  1      high while in INIT/PULSE/GAP (no arbitration)
//   S         out  1      latch set drive (registered)
//   R         out  1      latch reset drive (registered)
//   q_shadow  out  1      expected latch state
//   err       out  1      sticky: latch_q disagreed with q_shadow at a check
// ---------------------------------------------------------------------------
module sr_latch_ctrl #(
  parameter int N_REQ   = 4,
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] set_req,
  input  logic [N_REQ-1:0] clr_req,
  input  logic             latch_q,
  input  logic             err_clr,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic             S,
  output logic             R,
  output logic             q_shadow,
  output logic             err
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CNT_W = $clog2(MAX_W + 1);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_PULSE,
    ST_GAP
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [PTR_W-1:0] r_rr_ptr;
  logic [N_REQ-1:0] r_grant;
  logic             r_busy;
  logic             r_s;
  logic             r_r;
  logic             r_q_shadow;
  logic             r_err;

  logic [N_REQ-1:0] w_eligible;
  logic             w_found;
  logic [PTR_W-1:0] w_win_idx;
  logic [PTR_W-1:0] w_next_ptr;
  logic [N_REQ-1:0] w_win_onehot;
  logic             w_target;
  logic             w_check_pt;
  logic             w_mismatch;

  assign w_eligible = set_req | clr_req;

  // Round-robin search. Scan from r_rr_ptr upward and wrap. The first
  // requester with either request raised wins.
  always_comb begin : p_arb
    int idx;
    idx       = 0;
    w_found   = 1'b0;
    w_win_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!w_found && w_eligible[PTR_W'(idx)]) begin
        w_found   = 1'b1;
        w_win_idx = PTR_W'(idx);
      end
    end
  end

  // A clear request beats a set request from the same requester.
  assign w_target     = ~clr_req[w_win_idx];
  assign w_win_onehot = N_REQ'(1) << w_win_idx;
  assign w_next_ptr   = (w_win_idx == PTR_W'(N_REQ - 1)) ? '0 : w_win_idx + 1'b1;

  // The Q check happens only on the final edge of the guard gap.
  assign w_check_pt = (r_state == ST_GAP) && (r_cnt == CNT_W'(GAP_W - 1));
  assign w_mismatch = w_check_pt && (latch_q != r_q_shadow);

  // Controller FSM. S and R are only ever raised one at a time. Every exit
  // from a pulse passes through GAP, so the latch always sees the guard gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_cnt      <= '0;
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_busy     <= 1'b1;
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_q_shadow <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_grant <= '0;
      case (r_state)
        // Hold R for PULSE_W cycles. r_cnt counts the R-high cycles already
        // issued.
        ST_INIT: begin
          if (r_cnt == CNT_W'(PULSE_W)) begin
            r_r     <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_GAP;
          end else begin
            r_r   <= 1'b1;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        // A redundant request still gets its grant, but the latch is left
        // untouched.
        ST_IDLE: begin
          if (w_found) begin
            r_grant  <= w_win_onehot;
            r_rr_ptr <= w_next_ptr;
            if (w_target != r_q_shadow) begin
              r_q_shadow <= w_target;
              r_s        <= w_target;
              r_r        <= ~w_target;
              r_busy     <= 1'b1;
              r_cnt      <= '0;
              r_state    <= ST_PULSE;
            end
          end
        end
        ST_PULSE: begin
          if (r_cnt == CNT_W'(PULSE_W - 1)) begin
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (w_check_pt) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase

      // A mismatch in the same cycle as err_clr leaves err set.
      if (w_mismatch) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign grant    = r_grant;
  assign busy     = r_busy;
  assign S        = r_s;
  assign R        = r_r;
  assign q_shadow = r_q_shadow;
  assign err      = r_err;

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sr_latch_ctrl
//
// Drives sr_latch_ctrl (N_REQ=4, PULSE_W=2, GAP_W=1) with a behavioural SR
// latch on S/R/latch_q. Each grant-producing stimulus pushes its expected
// response into a queue. A forked monitor pops an entry each time the DUT
// raises grant. Directed checks cover pulse widths, err behaviour and reset.
// ---------------------------------------------------------------------------
module tb_sr_latch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] set_req = 4'b0000;
  logic [3:0] clr_req = 4'b0000;
  logic       latch_q;
  logic       err_clr = 1'b0;
  logic [3:0] grant;
  logic       busy;
  logic       S;
  logic       R;
  logic       q_shadow;
  logic       err;

  logic modelQ = 1'b1;
  logic forceZero = 1'b0;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int overlapCount = 0;

  typedef struct {
    logic [3:0] grant;
    logic       s;
    logic       r;
    logic       q;
    logic       busy;
    int         gap;
  } expT;

  expT expQ[$];

  sr_latch_ctrl #(
    .N_REQ(4),
    .PULSE_W(2),
    .GAP_W(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .set_req(set_req),
    .clr_req(clr_req),
    .latch_q(latch_q),
    .err_clr(err_clr),
    .grant(grant),
    .busy(busy),
    .S(S),
    .R(R),
    .q_shadow(q_shadow),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Behavioural SR latch. It starts at 1, so the INIT clear pulse has to
  // actually do its job.
  always @(S or R) begin
    if (S && !R) modelQ = 1'b1;
    else if (R && !S) modelQ = 1'b0;
  end

  assign latch_q = forceZero ? 1'b0 : modelQ;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: got no event within bound, expected one", name);
  endtask

  task automatic applyStimulus(input logic [3:0] setV, input logic [3:0] clrV);
    set_req = set_req | setV;
    clr_req = clr_req | clrV;
  endtask

  task automatic expectGrant(input logic [3:0] g, input logic s, input logic r,
                             input logic q, input logic b, input int gap);
    expT e;
    e.grant = g;
    e.s     = s;
    e.r     = r;
    e.q     = q;
    e.busy  = b;
    e.gap   = gap;
    expQ.push_back(e);
  endtask

  // Acts as the requester. Once a grant appears, it drops the granted bits.
  task automatic waitGrant(output logic [3:0] g);
    g = 4'b0000;
    for (int i = 0; i < 20 && g == 4'b0000; i++) begin
      @(negedge clk);
      g = grant;
    end
    if (g == 4'b0000) reportTimeout("waitGrant");
    set_req = set_req & ~g;
    clr_req = clr_req & ~g;
  endtask

  task automatic waitIdle();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (!busy) seen = 1'b1;
    end
    if (!seen) reportTimeout("waitIdle");
  endtask

  // Releases reset, then follows the INIT R pulse, the gap and the return
  // to idle.
  task automatic checkInitSequence();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("initR1", 32'(R), 1);
    checkOutput("initS1", 32'(S), 0);
    @(negedge clk);
    checkOutput("initR2", 32'(R), 1);
    checkOutput("initBusy2", 32'(busy), 1);
    @(negedge clk);
    checkOutput("initGapR", 32'(R), 0);
    checkOutput("initGapBusy", 32'(busy), 1);
    @(negedge clk);
    checkOutput("initIdleBusy", 32'(busy), 0);
    checkOutput("initShadow", 32'(q_shadow), 0);
    checkOutput("initErr", 32'(err), 0);
  endtask

  task automatic monitorLoop();
    expT e;
    int lastGrant;
    lastGrant = 0;
    forever begin
      @(negedge clk);
      if (rst_n && grant != 4'b0000) begin
        if (expQ.size() == 0) begin
          checkOutput("sbUnexpectedGrant", 32'(grant), 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("sbGrant", 32'(grant), 32'(e.grant));
          checkOutput("sbS", 32'(S), 32'(e.s));
          checkOutput("sbR", 32'(R), 32'(e.r));
          checkOutput("sbShadow", 32'(q_shadow), 32'(e.q));
          checkOutput("sbBusy", 32'(busy), 32'(e.busy));
          if (e.gap > 0) checkOutput("sbSpacing", 32'(cycle - lastGrant), 32'(e.gap));
        end
        lastGrant = cycle;
      end
    end
  endtask

  task automatic overlapWatch();
    forever begin
      @(negedge clk);
      if (S && R) overlapCount++;
    end
  endtask

  initial begin
    logic [3:0] g;
    fork
      monitorLoop();
      overlapWatch();
    join_none

    // Reset state, then the INIT clear sequence
    repeat (3) @(negedge clk);
    checkOutput("rstS", 32'(S), 0);
    checkOutput("rstR", 32'(R), 0);
    checkOutput("rstGrant", 32'(grant), 0);
    checkOutput("rstBusy", 32'(busy), 1);
    checkOutput("rstShadow", 32'(q_shadow), 0);
    checkOutput("rstErr", 32'(err), 0);
    checkInitSequence();

    // A single set request produces a two-cycle S pulse (ptr 0 -> 2)
    expectGrant(4'b0010, 1'b1, 1'b0, 1'b1, 1'b1, -1);
    applyStimulus(4'b0010, 4'b0000);
    waitGrant(g);
    @(negedge clk);
    checkOutput("t2SHeld", 32'(S), 1);
    @(negedge clk);
    checkOutput("t2SDone", 32'(S), 0);
    checkOutput("t2RLow", 32'(R), 0);
    checkOutput("t2BusyGap", 32'(busy), 1);
    waitIdle();
    checkOutput("t2Shadow", 32'(q_shadow), 1);
    checkOutput("t2Err", 32'(err), 0);

    // Set and clear from the same requester: clear wins (ptr 2 -> 2)
    expectGrant(4'b0010, 1'b0, 1'b1, 1'b0, 1'b1, -1);
    applyStimulus(4'b0010, 4'b0010);
    waitGrant(g);
    @(negedge clk);
    checkOutput("t4RHeld", 32'(R), 1);
    checkOutput("t4SLow", 32'(S), 0);
    waitIdle();
    checkOutput("t4Shadow", 32'(q_shadow), 0);

    // A redundant clear on requester 3 moves ptr back to 0 without a pulse
    expectGrant(4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    applyStimulus(4'b0000, 4'b1000);
    waitGrant(g);
    @(negedge clk);
    checkOutput("redNoS", 32'(S), 0);
    checkOutput("redNoR", 32'(R), 0);
    checkOutput("redGrantPulse", 32'(grant), 0);

    // Three held requests are served in round-robin order, four cycles apart
    expectGrant(4'b0001, 1'b1, 1'b0, 1'b1, 1'b1, -1);
    expectGrant(4'b0100, 1'b0, 1'b1, 1'b0, 1'b1, 4);
    expectGrant(4'b1000, 1'b1, 1'b0, 1'b1, 1'b1, 4);
    applyStimulus(4'b1001, 4'b0100);
    waitGrant(g);
    waitGrant(g);
    waitGrant(g);
    waitIdle();
    checkOutput("t3Shadow", 32'(q_shadow), 1);
    expectGrant(4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    applyStimulus(4'b0010, 4'b0000);
    waitGrant(g);
    @(negedge clk);
    checkOutput("t3RedBusy", 32'(busy), 0);
    checkOutput("t3RedS", 32'(S), 0);

    // With latch_q stuck at 0, a set request raises a sticky err
    expectGrant(4'b0100, 1'b0, 1'b1, 1'b0, 1'b1, -1);
    applyStimulus(4'b0000, 4'b0100);
    waitGrant(g);
    waitIdle();
    forceZero = 1'b1;
    expectGrant(4'b0001, 1'b1, 1'b0, 1'b1, 1'b1, -1);
    applyStimulus(4'b0001, 4'b0000);
    waitGrant(g);
    checkOutput("t5ErrDuringPulse", 32'(err), 0);
    waitIdle();
    checkOutput("t5ErrSet", 32'(err), 1);
    repeat (3) @(negedge clk);
    checkOutput("t5ErrSticky", 32'(err), 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("t5ErrCleared", 32'(err), 0);

    // A mismatch in the same cycle as err_clr leaves err set
    expectGrant(4'b0010, 1'b0, 1'b1, 1'b0, 1'b1, -1);
    applyStimulus(4'b0000, 4'b0010);
    waitGrant(g);
    waitIdle();
    checkOutput("t5NoErrOnClr", 32'(err), 0);
    err_clr = 1'b1;
    expectGrant(4'b1000, 1'b1, 1'b0, 1'b1, 1'b1, -1);
    applyStimulus(4'b1000, 4'b0000);
    waitGrant(g);
    waitIdle();
    checkOutput("t5SetWins", 32'(err), 1);
    err_clr = 1'b0;
    @(negedge clk);
    checkOutput("t5SetWinsSticky", 32'(err), 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("t5ErrCleared2", 32'(err), 0);
    forceZero = 1'b0;

    // An asynchronous reset in the middle of an S pulse
    expectGrant(4'b0001, 1'b0, 1'b1, 1'b0, 1'b1, -1);
    applyStimulus(4'b0000, 4'b0001);
    waitGrant(g);
    waitIdle();
    expectGrant(4'b0010, 1'b1, 1'b0, 1'b1, 1'b1, -1);
    applyStimulus(4'b0010, 4'b0000);
    waitGrant(g);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6SDropAsync", 32'(S), 0);
    checkOutput("t6GrantDrop", 32'(grant), 0);
    checkOutput("t6BusyReset", 32'(busy), 1);
    checkOutput("t6ShadowReset", 32'(q_shadow), 0);
    @(negedge clk);
    checkInitSequence();

    checkOutput("srNeverOverlap", 32'(overlapCount), 0);
    checkOutput("sbQueueDrained", 32'(expQ.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog: guarantees that the run ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected one");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
